hrav_downsize_fifo: RTL and testbench
=====================================

// Module: hrav_downsize_fifo
// PURPOSE
//  Parametrised width-down-converting FIFO: buffers wide words on the write side and returns them
//  as a stream of narrow lanes on the read side.
//  Sits between the wide datapath (e.g. 256-bit packet bus) and narrow consumers (byte/word engines).
//  Adds true full/empty with wrap, lane ordering mode, overflow/underflow flags and fill level.
// PARAMETERS
//  DIN_WIDTH   256  write word width; must be an integer multiple of DOUT_WIDTH
//  DOUT_WIDTH  8    read lane width
//  ADDR_WIDTH  4    log2 of entry count; depth = 2**ADDR_WIDTH wide words
//  MSB_FIRST   0    0: lane 0 = din[DOUT_WIDTH-1:0] read first; 1: most-significant lane read first
//  AFULL_LEVEL 12   almost_full asserts when used entries >= AFULL_LEVEL
// PORTS
//  clk          in   1               clock, all logic rising-edge
//  reset_n      in   1               asynchronous active-low reset
//  wr_en        in   1               write request
//  din          in   DIN_WIDTH       write data
//  rd_en        in   1               read request (one lane per accepted read)
//  dout         out  DOUT_WIDTH      read lane, valid when dout_valid
//  dout_valid   out  1               dout updated this cycle (1 cycle after accepted rd_en)
//  dout_last    out  1               with dout_valid: dout is final lane of its word
//  empty        out  1               no readable entry
//  full         out  1               all entries occupied
//  almost_full  out  1               used >= AFULL_LEVEL
//  used         out  ADDR_WIDTH+1    occupied entries (a partially read word counts as occupied)
//  overflow     out  1               1-cycle pulse: wr_en while full, write dropped
//  underflow    out  1               1-cycle pulse: rd_en while empty, read ignored
// BEHAVIOUR
//  - RATIO = DIN_WIDTH/DOUT_WIDTH. wr_ptr/rd_ptr are ADDR_WIDTH+1 bits; MSB gives wrap parity.
//    lane_idx counts 0..RATIO-1.
//  - Reset (async assert, sync-safe release): pointers, lane_idx, used = 0; empty=1; full=0;
//    almost_full=0; dout=0; dout_valid, dout_last, overflow, underflow = 0. Storage array is not reset.
//  - Flags are decoded from registered pointers only:
//      empty = (wr_ptr == rd_ptr)
//      full  = (addr bits equal, MSBs differ)
//      used  = wr_ptr - rd_ptr (modulo 2**(ADDR_WIDTH+1))
//  - Write: wr_en && !full -> mem[wr_ptr[ADDR_WIDTH-1:0]] <= din; wr_ptr++.
//  - Read: rd_en && !empty -> next edge dout <= selected lane of mem[rd_ptr]; dout_valid=1.
//    Lane select = lane_idx (MSB_FIRST=0) or RATIO-1-lane_idx (MSB_FIRST=1).
//    When lane_idx == RATIO-1: dout_last=1, lane_idx <= 0, rd_ptr++. Otherwise lane_idx++.
//    Latency rd_en -> dout_valid is 1 cycle; sustained 1 lane/cycle.
//  - Idle read: dout holds its last value; dout_valid=0, dout_last=0.
//  - Simultaneous read and write are both honoured in the same cycle.
//    A write is judged against current full: a write while full is dropped even if the same cycle
//    frees the entry.
//    A write into an empty FIFO is readable from the next cycle (no same-cycle passthrough).
//  - Pointer wrap at 2**ADDR_WIDTH is natural modulo; wrap parity keeps full/empty unambiguous.
//  - overflow/underflow: registered, high exactly one cycle per offending request; no state change.
//  - Reset mid-word discards the partial word: lane_idx returns to 0 and all contents are lost.
//  - RATIO == 1 is legal and behaves as a plain FIFO with dout_last=1 on every read.
// STRUCTURE
//  - Shared package hrav_fifo_pkg:
//      clog2 function
//      ratio/lane-index width computation
//      pointer-to-used helper
//    Reuse the same package across all hrav FIFOs.
//  - One sub-module, hrav_fifo_ram: simple dual-port array (1 write port, 1 sync read port), no reset.
//  - Top-level contains pointers, lane counter, flag decode and lane mux.
// TESTING
//  - Bench config: DIN_WIDTH=32, DOUT_WIDTH=8, ADDR_WIDTH=2, AFULL_LEVEL=3 unless stated.
//  1. Reset then write 0x44332211, read 4x (MSB_FIRST=0) -> dout 11,22,33,44;
//     dout_last only on 44; empty after the 4th read.
//  2. Same with MSB_FIRST=1 -> dout 44,33,22,11.
//  3. Write 4 words, no reads -> full=1, used=4, almost_full=1 from the 3rd write;
//     5th write -> overflow pulse, data unchanged on readback.
//  4. Full FIFO, read last lane of head word while wr_en=1 -> write dropped (overflow);
//     next cycle full=0, used=3.
//  5. Stream 12 words with continuous wr_en/rd_en (reads throttled by empty) -> 48 lanes in order,
//     pointers wrap 3x, no overflow/underflow.
//  6. rd_en on empty FIFO -> underflow pulse, dout_valid=0.
//     Assert reset_n low after 2 lanes of a word -> immediate empty=1, used=0, dout_valid=0;
//     new word reads from lane 0.

Source files
------------

// File: rtl/hrav_fifo_pkg.sv
// Shared helpers for the hrav FIFO family: log2 sizing, lane-index width and
// fill-level arithmetic on wrap-parity pointers.
package hrav_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    function automatic int lane_ratio(input int din_width, input int dout_width);
        return din_width / dout_width;
    endfunction

    // A ratio of 1 still needs a one-bit lane counter so the port widths stay legal.
    function automatic int lane_bits(input int ratio);
        return (ratio <= 1) ? 1 : clog2(ratio);
    endfunction

    function automatic int ptr_used(input int wr_ptr, input int rd_ptr, input int addr_width);
        return (wr_ptr - rd_ptr) & ((1 << (addr_width + 1)) - 1);
    endfunction

endpackage

// File: rtl/hrav_fifo_ram.sv
// Simple dual-port storage: one write port and one registered read port, no reset.
module hrav_fifo_ram #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/hrav_downsize_fifo.sv
// Width-down-converting FIFO: wide words in, a stream of narrow lanes out,
// with wrap-parity full/empty, fill level and overflow/underflow pulses.
module hrav_downsize_fifo
    import hrav_fifo_pkg::*;
#(
    parameter int DIN_WIDTH   = 256,
    parameter int DOUT_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter bit MSB_FIRST   = 1'b0,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  rd_en,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   used,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int RATIO = lane_ratio(DIN_WIDTH, DOUT_WIDTH);
    localparam int LW    = lane_bits(RATIO);
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    logic [ADDR_WIDTH:0]  wr_ptr;
    logic [ADDR_WIDTH:0]  rd_ptr;
    logic [LW-1:0]        lane_idx;
    logic [LW-1:0]        lane_sel;
    logic [LW-1:0]        lane_q;
    logic                 has_read;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 last_lane;
    logic [DIN_WIDTH-1:0] rd_word;

    always_comb begin
        empty       = (wr_ptr == rd_ptr);
        full        = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                      (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
        used        = (ADDR_WIDTH+1)'(ptr_used(int'(wr_ptr), int'(rd_ptr), ADDR_WIDTH));
        almost_full = (int'(used) >= AFULL_LEVEL);
        wr_ok       = wr_en && !full;
        rd_ok       = rd_en && !empty;
        last_lane   = (lane_idx == LAST_LANE);
        lane_sel    = MSB_FIRST ? (LAST_LANE - lane_idx) : lane_idx;
    end

    hrav_fifo_ram #(
        .DATA_WIDTH (DIN_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (din),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_word)
    );

    // The RAM read register is not reset, so dout is forced to zero until the first read after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lane_idx   <= '0;
            lane_q     <= '0;
            has_read   <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= rd_ok;
            dout_last  <= rd_ok && last_lane;
            overflow   <= wr_en && full;
            underflow  <= rd_en && empty;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                lane_q   <= lane_sel;
                has_read <= 1'b1;
                if (last_lane) begin
                    lane_idx <= '0;
                    rd_ptr   <= rd_ptr + 1'b1;
                end else begin
                    lane_idx <= lane_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        dout = '0;
        if (has_read) begin
            dout = rd_word[int'(lane_q)*DOUT_WIDTH +: DOUT_WIDTH];
        end
    end

endmodule

// File: tb/tb_hrav_downsize_fifo.sv
// Scoreboard bench: two DUTs (LSB-first and MSB-first lane order) share stimulus;
// expected lanes are queued at issue and popped by a monitor on each dout_valid.
module tb_hrav_downsize_fifo;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [31:0] din;
    logic        rd_en;

    logic [7:0]  a_dout, b_dout;
    logic        a_valid, b_valid, a_last, b_last;
    logic        a_empty, b_empty, a_full, b_full, a_afull, b_afull;
    logic [2:0]  a_used, b_used;
    logic        a_ovf, b_ovf, a_udf, b_udf;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   fails  = 0;

    hrav_downsize_fifo #(
        .DIN_WIDTH(32), .DOUT_WIDTH(8), .ADDR_WIDTH(2), .MSB_FIRST(1'b0), .AFULL_LEVEL(3)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(a_dout), .dout_valid(a_valid), .dout_last(a_last), .empty(a_empty),
        .full(a_full), .almost_full(a_afull), .used(a_used), .overflow(a_ovf),
        .underflow(a_udf)
    );

    hrav_downsize_fifo #(
        .DIN_WIDTH(32), .DOUT_WIDTH(8), .ADDR_WIDTH(2), .MSB_FIRST(1'b1), .AFULL_LEVEL(3)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(b_dout), .dout_valid(b_valid), .dout_last(b_last), .empty(b_empty),
        .full(b_full), .almost_full(b_afull), .used(b_used), .overflow(b_ovf),
        .underflow(b_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic w, input logic [31:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Lane k of a word: LSB-first DUT gets byte k, MSB-first DUT gets byte 3-k.
    task automatic push_lane(input logic [31:0] w, input int k);
        exp_t e;
        e.last = (k == 3);
        e.data = w[8*k +: 8];
        q_a.push_back(e);
        e.data = w[8*(3-k) +: 8];
        q_b.push_back(e);
    endtask

    function automatic logic [31:0] stream_word(input int k);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
            w[8*j +: 8] = 8'(k*4 + j);
        end
        return w;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (a_valid) begin
            if (q_a.size() == 0) begin
                check_output("a_unexpected_valid", 32'(a_dout), 32'hFFFF_FFFF);
            end else begin
                e = q_a.pop_front();
                check_output("a_lane_data", 32'(a_dout), 32'(e.data));
                check_output("a_lane_last", 32'(a_last), 32'(e.last));
            end
        end
        if (b_valid) begin
            if (q_b.size() == 0) begin
                check_output("b_unexpected_valid", 32'(b_dout), 32'hFFFF_FFFF);
            end else begin
                e = q_b.pop_front();
                check_output("b_lane_data", 32'(b_dout), 32'(e.data));
                check_output("b_lane_last", 32'(b_last), 32'(e.last));
            end
        end
    end

    initial begin
        int sent, rd_lanes, mu, ml, head;
        logic w, r;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_empty", 32'(a_empty), 1);
        check_output("rst_full", 32'(a_full), 0);
        check_output("rst_afull", 32'(a_afull), 0);
        check_output("rst_used", 32'(a_used), 0);
        check_output("rst_dout", 32'(a_dout), 0);
        check_output("rst_valid", 32'(a_valid), 0);
        check_output("rst_flags", {a_last, a_ovf, a_udf, b_last, b_ovf, b_udf}, 0);
        reset_n = 1'b1;

        // Single word, read back as four lanes in both orders.
        apply_stimulus(1'b1, 32'h4433_2211, 1'b0);
        check_output("t1_not_empty", 32'(a_empty), 0);
        check_output("t1_used", 32'(a_used), 1);
        for (int k = 0; k < 4; k++) begin
            push_lane(32'h4433_2211, k);
            apply_stimulus(1'b0, '0, 1'b1);
        end
        check_output("t1_empty_after", 32'(a_empty), 1);
        apply_stimulus(1'b0, '0, 1'b0);
        check_output("t1_a_hold", 32'(a_dout), 32'h44);
        check_output("t1_b_hold", 32'(b_dout), 32'h11);
        check_output("t1_idle_valid", 32'({a_valid, a_last}), 0);

        // Fill to full, then overflow.
        apply_stimulus(1'b1, 32'hA3A2_A1A0, 1'b0);
        check_output("t3_used1", 32'(a_used), 1);
        apply_stimulus(1'b1, 32'hB3B2_B1B0, 1'b0);
        check_output("t3_afull2", 32'(a_afull), 0);
        apply_stimulus(1'b1, 32'hC3C2_C1C0, 1'b0);
        check_output("t3_afull3", 32'(a_afull), 1);
        check_output("t3_full3", 32'(a_full), 0);
        apply_stimulus(1'b1, 32'hD3D2_D1D0, 1'b0);
        check_output("t3_full4", 32'(b_full), 1);
        check_output("t3_used4", 32'(a_used), 4);
        apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
        check_output("t3_overflow", 32'({a_ovf, b_ovf}), 32'h3);
        check_output("t3_used_hold", 32'(a_used), 4);
        apply_stimulus(1'b0, '0, 1'b0);
        check_output("t3_overflow_pulse", 32'(a_ovf), 0);

        // Write while full is dropped even as the last lane frees an entry.
        for (int k = 0; k < 3; k++) begin
            push_lane(32'hA3A2_A1A0, k);
            apply_stimulus(1'b0, '0, 1'b1);
        end
        push_lane(32'hA3A2_A1A0, 3);
        apply_stimulus(1'b1, 32'hBADB_AD00, 1'b1);
        check_output("t4_overflow", 32'(a_ovf), 1);
        check_output("t4_full", 32'(a_full), 0);
        check_output("t4_used", 32'(a_used), 3);
        for (int k = 0; k < 4; k++) begin
            push_lane(32'hB3B2_B1B0, k);
            apply_stimulus(1'b0, '0, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            push_lane(32'hC3C2_C1C0, k);
            apply_stimulus(1'b0, '0, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            push_lane(32'hD3D2_D1D0, k);
            apply_stimulus(1'b0, '0, 1'b1);
        end
        check_output("t4_empty", 32'(a_empty), 1);

        // Concurrent streaming of 12 words, gated by a model of occupancy.
        sent = 0; rd_lanes = 0; mu = 0; ml = 0; head = 0;
        for (int cyc = 0; cyc < 200 && rd_lanes < 48; cyc++) begin
            w = (sent < 12) && (mu < 4);
            r = (mu > 0);
            if (r) push_lane(stream_word(head), ml);
            apply_stimulus(w, stream_word(sent), r);
            if (r) begin
                rd_lanes++;
                if (ml == 3) begin
                    ml = 0;
                    head++;
                    mu--;
                end else begin
                    ml++;
                end
            end
            if (w) begin
                sent++;
                mu++;
            end
            check_output("t5_no_ovf_udf", 32'({a_ovf, a_udf, b_ovf, b_udf}), 0);
            check_output("t5_used", 32'(a_used), 32'(mu));
        end
        check_output("t5_lanes_done", 32'(rd_lanes), 48);
        apply_stimulus(1'b0, '0, 1'b0);

        // Underflow, then reset in the middle of a word.
        apply_stimulus(1'b0, '0, 1'b1);
        check_output("t6_underflow", 32'({a_udf, b_udf}), 32'h3);
        check_output("t6_udf_valid", 32'(a_valid), 0);
        apply_stimulus(1'b0, '0, 1'b0);
        check_output("t6_udf_pulse", 32'(a_udf), 0);
        apply_stimulus(1'b1, 32'h0D0C_0B0A, 1'b0);
        for (int k = 0; k < 2; k++) begin
            push_lane(32'h0D0C_0B0A, k);
            apply_stimulus(1'b0, '0, 1'b1);
        end
        apply_stimulus(1'b0, '0, 1'b0);
        reset_n = 1'b0;
        #1;
        check_output("t6_rst_empty", 32'(a_empty), 1);
        check_output("t6_rst_used", 32'(a_used), 0);
        check_output("t6_rst_valid", 32'({a_valid, b_valid}), 0);
        check_output("t6_rst_dout", 32'({a_dout, b_dout}), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply_stimulus(1'b1, 32'h8765_4321, 1'b0);
        for (int k = 0; k < 4; k++) begin
            push_lane(32'h8765_4321, k);
            apply_stimulus(1'b0, '0, 1'b1);
        end
        apply_stimulus(1'b0, '0, 1'b0);
        check_output("t6_empty_end", 32'(a_empty), 1);
        check_output("queue_a_drained", 32'(q_a.size()), 0);
        check_output("queue_b_drained", 32'(q_b.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
